// File: rtl/decode_pipe_reg_pkg.sv
// Shared types and default widths for the decode-to-execute pipeline register.
package decode_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_CWIDTH = 16;
  localparam int PAYLOAD_W  = 5 * DEF_DWIDTH;

  typedef struct packed {
    logic [DEF_DWIDTH-1:0] addr;
    logic [DEF_DWIDTH-1:0] immed;
    logic [DEF_DWIDTH-1:0] inst;
    logic [DEF_DWIDTH-1:0] rd1;
    logic [DEF_DWIDTH-1:0] rd2;
  } decode_payload_t;

endpackage

// File: rtl/decode_pipe_reg_if.sv
// Handshake and payload bundle between decode (master) and the pipeline register (slave).
interface decode_pipe_reg_if
  import decode_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int CWIDTH = DEF_CWIDTH
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] addr;
  logic [DWIDTH-1:0] immed;
  logic [DWIDTH-1:0] inst;
  logic [DWIDTH-1:0] Rd1;
  logic [DWIDTH-1:0] Rd2;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] stored_addr;
  logic [DWIDTH-1:0] stored_immed;
  logic [DWIDTH-1:0] stored_inst;
  logic [DWIDTH-1:0] stored_Rd1;
  logic [DWIDTH-1:0] stored_Rd2;
  logic [CWIDTH-1:0] stall_count;

  modport master (
    output in_valid, addr, immed, inst, Rd1, Rd2, flush, out_ready,
    input  in_ready, out_valid, stored_addr, stored_immed, stored_inst,
           stored_Rd1, stored_Rd2, stall_count
  );

  modport slave (
    input  in_valid, addr, immed, inst, Rd1, Rd2, flush, out_ready,
    output in_ready, out_valid, stored_addr, stored_immed, stored_inst,
           stored_Rd1, stored_Rd2, stall_count
  );

endinterface

// File: rtl/decode_pipe_reg_skid_slot.sv
// One-entry payload holder with a full flag; push fills it, pop or flush empties it.
module decode_skid_slot #(
  parameter int W = 160
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o
);

  logic         full_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (flush_i) begin
      full_q <= 1'b0;
    end else if (push_i) begin
      full_q <= 1'b1;
      data_q <= din_i;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end
  end

  assign dout_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/decode_pipe_reg.sv
// Decode-to-execute pipeline register with valid/ready, flush and a saturating stall counter.
// Optional skid slot (registered in_ready) enabled by defining DECODE_SKID_EN.
module decode_pipe_reg
  import decode_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int CWIDTH = DEF_CWIDTH
) (
  input logic              clk,
  input logic              rst,
  decode_pipe_reg_if.slave bus
);

  localparam int PW = 5 * DWIDTH;

`ifdef DECODE_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  logic [PW-1:0]     in_pl;
  logic [PW-1:0]     main_q, main_d;
  logic              valid_q, valid_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic              drain, load_en, accept, in_ready;
  logic              src_valid;
  logic [PW-1:0]     src_pl;

  assign in_pl   = {bus.addr, bus.immed, bus.inst, bus.Rd1, bus.Rd2};
  assign drain   = valid_q & bus.out_ready;
  assign load_en = ~valid_q | drain;
  assign accept  = bus.in_valid & in_ready;

  generate
    if (SKID_EN) begin : g_skid
      logic          skid_full, skid_push, skid_pop, ready_q;
      logic [PW-1:0] skid_pl;

      // An accept that cannot enter the stalled main register parks in the skid slot.
      assign skid_push = accept & ~load_en & ~bus.flush;
      assign skid_pop  = load_en & skid_full & ~bus.flush;

      decode_skid_slot #(.W(PW)) u_skid (
        .clk     (clk),
        .srst    (rst),
        .flush_i (bus.flush),
        .push_i  (skid_push),
        .pop_i   (skid_pop),
        .din_i   (in_pl),
        .dout_o  (skid_pl),
        .full_o  (skid_full)
      );

      always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= ~((skid_full & ~skid_pop) | skid_push);
        end
      end

      assign in_ready  = ready_q & ~rst;
      assign src_valid = skid_full | accept;
      assign src_pl    = skid_full ? skid_pl : in_pl;
    end else begin : g_noskid
      assign in_ready  = ~rst & load_en;
      assign src_valid = accept;
      assign src_pl    = in_pl;
    end
  endgenerate

  always_comb begin
    valid_d = valid_q;
    main_d  = main_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      main_d  = '0;
    end else if (load_en) begin
      valid_d = src_valid;
      if (src_valid) begin
        main_d = src_pl;
      end
    end
    // A flush cycle is a kill, not a stall, so it leaves the counter alone.
    if (valid_q && !bus.out_ready && !bus.flush && (cnt_q != {CWIDTH{1'b1}})) begin
      cnt_d = cnt_q + CWIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      main_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      main_q  <= main_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = valid_q;
  assign {bus.stored_addr, bus.stored_immed, bus.stored_inst,
          bus.stored_Rd1, bus.stored_Rd2} = main_q;
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_decode_pipe_reg.sv
// Randomised scoreboard bench for decode_pipe_reg; the model is a queue of resident payloads.
module tb_decode_pipe_reg;
  import decode_pkg::*;

  localparam int DW      = DEF_DWIDTH;
  localparam int CW      = 4;
  localparam int PW      = 5 * DW;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef DECODE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_pipe_reg_if #(.DWIDTH(DW), .CWIDTH(CW)) bus ();

  decode_pipe_reg #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [PW-1:0] exp_q[$];
  int  cnt_m      = 0;
  bit  exp_zero   = 1'b1;
  bit  exp_accept = 1'b0;

  function automatic void check(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [PW-1:0] mk(logic [DW-1:0] a, logic [DW-1:0] im,
                                        logic [DW-1:0] in, logic [DW-1:0] r1,
                                        logic [DW-1:0] r2);
    decode_payload_t p;
    p.addr  = a;
    p.immed = im;
    p.inst  = in;
    p.rd1   = r1;
    p.rd2   = r2;
    return p;
  endfunction

  function automatic logic [PW-1:0] rnd_pl();
    return mk($urandom, $urandom, $urandom, $urandom, $urandom);
  endfunction

  // Monitor: compares the DUT against the resident-payload queue, then advances the model.
  initial begin
    logic [PW-1:0] dut_pl;
    bit exp_rdy;
    @(posedge clk);
    forever begin
      @(negedge clk);
      dut_pl = {bus.stored_addr, bus.stored_immed, bus.stored_inst,
                bus.stored_Rd1, bus.stored_Rd2};
      exp_rdy = !rst && (SKID ? (exp_q.size() < 2)
                              : (exp_q.size() == 0 || bus.out_ready));
      check("in_ready", PW'(bus.in_ready), PW'(exp_rdy));
      check("out_valid", PW'(bus.out_valid), PW'(exp_q.size() > 0));
      if (exp_q.size() > 0)
        check("stored", dut_pl, exp_q[0]);
      else if (exp_zero)
        check("stored_zero", dut_pl, '0);
      check("stall_count", PW'(bus.stall_count), PW'(cnt_m));
      exp_accept = bus.in_valid && exp_rdy && !bus.flush && !rst;
      if (rst) begin
        exp_q.delete();
        cnt_m    = 0;
        exp_zero = 1'b1;
      end else begin
        if (exp_q.size() > 0 && !bus.out_ready && !bus.flush && cnt_m < CNT_MAX)
          cnt_m++;
        if (exp_q.size() > 0 && bus.out_ready) begin
          $display("drain addr=%h immed=%h inst=%h rd1=%h rd2=%h",
                   dut_pl[5*DW-1:4*DW], dut_pl[4*DW-1:3*DW], dut_pl[3*DW-1:2*DW],
                   dut_pl[2*DW-1:DW], dut_pl[DW-1:0]);
          void'(exp_q.pop_front());
        end
        if (bus.flush) begin
          exp_q.delete();
          exp_zero = 1'b1;
        end
      end
    end
  end

  task automatic cyc(bit iv, bit orr, bit fl, bit r, logic [PW-1:0] pl);
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    {bus.addr, bus.immed, bus.inst, bus.Rd1, bus.Rd2} = pl;
    bus.out_ready = orr;
    bus.flush     = fl;
    rst           = r;
    @(negedge clk);
    #1;
    if (exp_accept) begin
      exp_q.push_back(pl);
      exp_zero = 1'b0;
    end
  endtask

  task automatic chk_count(int e);
    check("stall_count_dir", PW'(bus.stall_count), PW'(e));
  endtask

  initial begin
    int saved;
    bus.in_valid  = 1'b0;
    bus.addr      = '0;
    bus.immed     = '0;
    bus.inst      = '0;
    bus.Rd1       = '0;
    bus.Rd2       = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset then a single transfer
    cyc(0, 0, 0, 1, '0);
    cyc(0, 0, 0, 1, '0);
    cyc(1, 1, 0, 0, mk(8, 10, 32'h18C7F000, 31, 3));
    cyc(0, 1, 0, 0, '0);
    cyc(0, 1, 0, 0, '0);

    // Back-pressure for 5 cycles; second payload lands in the skid slot when present
    cyc(0, 1, 0, 1, '0);
    cyc(1, 0, 0, 0, mk(1, 2, 3, 4, 5));
    for (int k = 0; k < 5; k++)
      cyc(k == 0, 0, 0, 0, mk(20, 50, 0, 28, 10));
    cyc(0, 1, 0, 0, '0);
    chk_count(5);
    cyc(0, 1, 0, 0, '0);
    cyc(0, 1, 0, 0, '0);

    // Full throughput
    for (int k = 0; k < 8; k++)
      cyc(1, 1, 0, 0, mk(k, $urandom, $urandom, $urandom, $urandom));
    cyc(0, 1, 0, 0, '0);
    cyc(0, 1, 0, 0, '0);

    // Flush with output stalled (and skid full when present)
    cyc(1, 0, 0, 0, rnd_pl());
    cyc(1, 0, 0, 0, rnd_pl());
    saved = cnt_m;
    cyc(1, 0, 1, 0, rnd_pl());
    cyc(0, 0, 0, 0, '0);
    chk_count(saved);
    check("flush_out_valid", PW'(bus.out_valid), '0);
    check("flush_in_ready", PW'(bus.in_ready), PW'(1));
    // Flush with a drain and an accept in the same cycle
    cyc(1, 1, 0, 0, rnd_pl());
    cyc(1, 1, 1, 0, rnd_pl());
    cyc(0, 1, 0, 0, '0);

    // Counter saturation
    cyc(0, 1, 0, 1, '0);
    cyc(1, 0, 0, 0, rnd_pl());
    for (int k = 0; k < 20; k++)
      cyc(0, 0, 0, 0, '0);
    chk_count(CNT_MAX);
    cyc(0, 1, 0, 0, '0);

    // Reset mid-stall
    cyc(1, 0, 0, 0, rnd_pl());
    cyc(0, 0, 0, 0, '0);
    cyc(1, 1, 0, 1, rnd_pl());
    for (int k = 0; k < 3; k++)
      cyc(0, 1, 0, 0, '0);

    // Random traffic
    for (int k = 0; k < 600; k++)
      cyc(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0,
          ($urandom % 80) == 0, rnd_pl());
    cyc(0, 1, 0, 0, '0);
    cyc(0, 1, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_pipe_reg.md
# decode_pipe_reg

Parametrised decode-to-execute pipeline register: the successor to the plain `decode` register, which stored addr/immed/inst/Rd1/Rd2 every clock. It adds a valid/ready handshake, back-pressure, flush (bubble insertion on branch/exception), a saturating stall counter and an optional skid slot that breaks the combinational ready path. It sits between the register-file read in decode and the execute stage.

## Interface
- `DWIDTH`, 32: width of every payload field.
- `CWIDTH`, 16: width of the stall counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  decode presents a payload.
- `in_ready`  out  1  block accepts the payload this cycle.
- `addr`, `immed`, `inst`, `Rd1`, `Rd2`  in  DWIDTH each  incoming payload.
- `flush`  in  1  kill all resident and incoming payloads.
- `out_valid`  out  1  stored payload valid toward execute.
- `out_ready`  in  1  execute consumes the payload this cycle.
- `stored_addr`, `stored_immed`, `stored_inst`, `stored_Rd1`, `stored_Rd2`  out  DWIDTH each  registered payload.
- `stall_count`  out  CWIDTH  cycles with `out_valid && !out_ready`, saturating.

## Operation
- Accept: `in_valid && in_ready` at an edge. Output drain: `out_valid && out_ready` at an edge.
- Main register loads on accept when it is empty or draining in the same cycle; an accept and a drain in the same cycle is allowed, giving full throughput with no bubble.
- Stalled (`out_valid && !out_ready`): `out_valid` and all `stored_*` hold bit-exact.
- `flush` has priority over everything except `rst`. On the next edge, `out_valid` goes to 0, the skid slot is emptied, all `stored_*` go to 0, and any payload accepted in that cycle is dropped.
- `stall_count` increments by 1 per stalled cycle. It saturates at 2^CWIDTH-1 and never wraps. `flush` does not clear it; only `rst` does.
- Arithmetic: the counter is unsigned. Payload fields pass through unmodified; there is no sign extension.

## Timing
- Reset values: `out_valid`=0, all `stored_*`=0, `stall_count`=0. `in_ready`=0 while `rst` is high.
- Latency: 1 cycle. A payload accepted at edge N is visible on `stored_*` after edge N with `out_valid`=1.
- Reset mid-transfer: all payloads are discarded and no partial state survives.
- `rst` and `flush` together: `rst` governs; the result is identical to reset.
- `flush` with `out_ready`=1 and `in_valid`=1 in the same cycle: the drain occurs, the incoming payload is dropped, and the block is empty afterwards.

## Configuration
- `DECODE_SKID_EN` defined:
  - Adds a one-entry skid slot, and `in_ready` becomes a flop output equal to "skid empty".
  - A payload accepted while the output is stalled goes into the skid slot, and `in_ready` drops at the next edge.
  - On the next drain, the skid payload moves to the main register in the same cycle, and `in_ready` returns to 1 at the following edge.
  - No combinational path exists from `out_ready` to `in_ready`.
- `DECODE_SKID_EN` undefined:
  - `in_ready = !rst && (!out_valid || out_ready)`, purely combinational.
  - There is a single storage entry.

## Structure
- `decode_pkg` holds:
  - the `decode_payload_t` packed struct (addr, immed, inst, rd1, rd2);
  - `PAYLOAD_W = 5*DWIDTH`;
  - the default widths.
- One sub-module, `decode_skid_slot`: a one-entry payload holder with a full flag. It is instantiated only under `DECODE_SKID_EN`.

## Test plan
- Reset, then a single transfer:
  - Stimulus: `rst` held 2 cycles, then addr=8, immed=10, inst=0x18C7F000, Rd1=31, Rd2=3 with `in_valid`=1 and `out_ready`=1.
  - Response: outputs 0 during reset; one edge after the accept, `stored_*` equal the inputs and `out_valid`=1.
- Back-pressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles with the payload resident.
  - Response: `stored_*` stable, `stall_count`=5.
  - With skid: a second payload (addr=20, immed=50, Rd1=28, Rd2=10) is accepted once, then `in_ready`=0. After `out_ready` is raised, the first payload drains and the second follows on the next cycle.
- Full throughput:
  - Stimulus: 8 back-to-back payloads with addr=0..7 and `out_ready`=1.
  - Response: the 8 payloads appear on 8 consecutive cycles, in order, with no bubble.
- Flush:
  - Stimulus: assert `flush` in the same cycle as an accept, with the output stalled and (with skid) the skid slot full.
  - Response: next cycle `out_valid`=0, `stored_*`=0, skid empty, `in_ready`=1, and `stall_count` unchanged.
- Counter saturation:
  - Stimulus: CWIDTH=4, stall for 20 cycles.
  - Response: `stall_count` stops at 15.
- Reset mid-stall:
  - Stimulus: assert `rst` for 1 cycle while a payload is stalled.
  - Response: all outputs return to their reset values and the payload never appears.
